// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset pulse, lock wait/retry and downstream reset release sequencer
//
// Purpose:
//   Pulses the PLL reset, waits for a synchronized lock indication with a
//   timeout, retries a bounded number of times, and releases the downstream
//   system reset once lock has been continuously stable for a programmable
//   interval. Loss of lock in RUN or a relock request restarts the sequence.
//
// Ports:
//   refclk        in   reference clock (only clock of the block)
//   rst           in   asynchronous active-high reset
//   pll_locked    in   PLL lock output, asynchronous to refclk
//   relock_req    in   synchronous pulse, forces a full re-sequence
//   pll_rst       out  PLL reset drive
//   sys_rst       out  active-high reset for downstream logic
//   ready         out  high while locked and stable (RUN)
//   fail          out  lock not achieved within the retry budget
//   retry_count   out  retries used in the current sequence
//   lock_loss_cnt out  saturating count of lock losses while in RUN

module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES   = 16,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_count,
  output logic [7:0] lock_loss_cnt
);

  // One shared counter sized for the largest interval it has to reach.
  localparam int MAX_AB   = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_ALL  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CW       = (MAX_ALL > 1) ? $clog2(MAX_ALL + 1) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [2:0]    RETRY_MAX   = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    retry_n;
  logic [7:0]    llc_n;
  logic          pll_rst_n, sys_rst_n, ready_n, fail_n;

  // Two-flop synchronizer; the FSM looks only at locked_s.
  logic [1:0] sync;
  logic       locked_s;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], pll_locked};
    end
  end

  assign locked_s = sync[1];

  // State, counter and all outputs are registered; outputs are decoded from
  // the next state so they change on the same edge as the state does.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state         <= S_RESET_PLL;
      cnt           <= '0;
      retry_count   <= 3'd0;
      lock_loss_cnt <= 8'd0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      retry_count   <= retry_n;
      lock_loss_cnt <= llc_n;
      pll_rst       <= pll_rst_n;
      sys_rst       <= sys_rst_n;
      ready         <= ready_n;
      fail          <= fail_n;
    end
  end

  always_comb begin
    state_n = state;
    retry_n = retry_count;
    llc_n   = lock_loss_cnt;

    if (relock_req) begin
      // Highest priority from any state; lock_loss_cnt is deliberately kept.
      state_n = S_RESET_PLL;
      retry_n = 3'd0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_n = S_WAIT_LOCK;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_n = S_STABILIZE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_count == RETRY_MAX) begin
              state_n = S_FAIL;
            end else begin
              retry_n = retry_count + 3'd1;
              state_n = S_RESET_PLL;
            end
          end
        end
        S_STABILIZE: begin
          // A lock drop does not consume a retry; the timeout simply restarts.
          if (!locked_s) begin
            state_n = S_WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_n = S_RUN;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_n = S_RESET_PLL;
            retry_n = 3'd0;
            if (lock_loss_cnt != 8'hFF) begin
              llc_n = lock_loss_cnt + 8'd1;
            end
          end
        end
        S_FAIL: begin
          state_n = S_FAIL;
        end
        default: begin
          state_n = S_RESET_PLL;
        end
      endcase
    end

    // Counter clears on every state change (and on a relock that re-enters
    // RESET_PLL); it only runs in the timed states so it never wraps.
    if (relock_req || (state_n != state)) begin
      cnt_n = '0;
    end else if ((state == S_RESET_PLL) || (state == S_WAIT_LOCK) || (state == S_STABILIZE)) begin
      cnt_n = cnt + 1'b1;
    end else begin
      cnt_n = cnt;
    end

    pll_rst_n = (state_n == S_RESET_PLL) || (state_n == S_FAIL);
    sys_rst_n = (state_n != S_RUN);
    ready_n   = (state_n == S_RUN);
    fail_n    = (state_n == S_FAIL);
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - scoreboard bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [2:0] retry_count;
  logic [7:0] lock_loss_cnt;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES  (4),
    .LOCK_TIMEOUT      (20),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES       (2)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .fail         (fail),
    .retry_count  (retry_count),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int          cyc;
    logic [14:0] val;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge refclk) cyc <= cyc + 1;

  // Monitor: at every falling edge, compare all expectations due now.
  always @(negedge refclk) begin : monitor
    int i;
    logic [14:0] act;
    act = {pll_rst, sys_rst, ready, fail, retry_count, lock_loss_cnt};
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc == cyc) begin
        n_cmp = n_cmp + 1;
        if (act !== q[i].val) begin
          n_err = n_err + 1;
          $display("FAIL %s @cyc %0d: got pr=%b sr=%b rdy=%b fl=%b rc=%0d llc=%0d, expected pr=%b sr=%b rdy=%b fl=%b rc=%0d llc=%0d",
                   q[i].tag, cyc, act[14], act[13], act[12], act[11], act[10:8], act[7:0],
                   q[i].val[14], q[i].val[13], q[i].val[12], q[i].val[11], q[i].val[10:8], q[i].val[7:0]);
        end
        q.delete(i);
      end else if (q[i].cyc < cyc) begin
        n_cmp = n_cmp + 1;
        n_err = n_err + 1;
        $display("FAIL %s: check for cycle %0d never sampled (now %0d), expected %h", q[i].tag, q[i].cyc, cyc, q[i].val);
        q.delete(i);
      end else begin
        i = i + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic expect_at(input int off, input logic pr, input logic sr, input logic rd, input logic fl,
                           input logic [2:0] rc, input logic [7:0] llc, input string tag);
    exp_t e;
    e.cyc = cyc + off;
    e.val = {pr, sr, rd, fl, rc, llc};
    e.tag = tag;
    q.push_back(e);
  endtask

  initial begin : stim
    int prev_l;
    int cur_l;
    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    tick(2);

    // Reset values, then normal start: pll_rst high 4 cycles, lock 10 later.
    expect_at(0, 1, 1, 0, 0, 3'd0, 8'd0, "reset_values");
    rst = 1'b0;
    expect_at(3, 1, 1, 0, 0, 3'd0, 8'd0, "start_pulse_last");
    expect_at(4, 0, 1, 0, 0, 3'd0, 8'd0, "start_pulse_fall");
    tick(14);
    pll_locked = 1'b1;
    expect_at(10, 0, 1, 0, 0, 3'd0, 8'd0, "start_before_run");
    expect_at(11, 0, 0, 1, 0, 3'd0, 8'd0, "start_run");
    tick(13);

    // relock_req in RUN, then a lock glitch at stabilize cycle 5.
    relock_req = 1'b1;
    expect_at(0, 0, 0, 1, 0, 3'd0, 8'd0, "run_before_relock");
    expect_at(1, 1, 1, 0, 0, 3'd0, 8'd0, "relock_in_run");
    expect_at(4, 1, 1, 0, 0, 3'd0, 8'd0, "relock_pulse_last");
    expect_at(5, 0, 1, 0, 0, 3'd0, 8'd0, "relock_wait");
    tick(1);
    relock_req = 1'b0;
    tick(10);
    pll_locked = 1'b0;
    expect_at(2, 0, 1, 0, 0, 3'd0, 8'd0, "glitch_stab");
    expect_at(3, 0, 1, 0, 0, 3'd0, 8'd0, "glitch_no_run");
    tick(3);
    pll_locked = 1'b1;
    expect_at(10, 0, 1, 0, 0, 3'd0, 8'd0, "glitch_relock_pre");
    expect_at(11, 0, 0, 1, 0, 3'd0, 8'd0, "glitch_relock_run");
    tick(11);

    // Loss of lock in RUN, repeated past saturation of lock_loss_cnt.
    for (int i = 1; i <= 260; i++) begin
      prev_l = (i - 1 > 255) ? 255 : i - 1;
      cur_l  = (i > 255) ? 255 : i;
      pll_locked = 1'b0;
      expect_at(2, 0, 0, 1, 0, 3'd0, 8'(prev_l), "loss_pre");
      expect_at(3, 1, 1, 0, 0, 3'd0, 8'(cur_l), "loss_drop");
      expect_at(6, 1, 1, 0, 0, 3'd0, 8'(cur_l), "loss_pulse_last");
      expect_at(7, 0, 1, 0, 0, 3'd0, 8'(cur_l), "loss_wait");
      tick(7);
      pll_locked = 1'b1;
      expect_at(10, 0, 1, 0, 0, 3'd0, 8'(cur_l), "loss_relock_pre");
      expect_at(11, 0, 0, 1, 0, 3'd0, 8'(cur_l), "loss_relock_run");
      tick(11);
    end

    // Timeout/retry into FAIL (lock_loss_cnt stays saturated).
    pll_locked = 1'b0;
    expect_at(3,  1, 1, 0, 0, 3'd0, 8'd255, "to_pulse0");
    expect_at(6,  1, 1, 0, 0, 3'd0, 8'd255, "to_pulse0_last");
    expect_at(7,  0, 1, 0, 0, 3'd0, 8'd255, "to_wait0");
    expect_at(26, 0, 1, 0, 0, 3'd0, 8'd255, "to_wait0_last");
    expect_at(27, 1, 1, 0, 0, 3'd1, 8'd255, "to_pulse1");
    expect_at(30, 1, 1, 0, 0, 3'd1, 8'd255, "to_pulse1_last");
    expect_at(31, 0, 1, 0, 0, 3'd1, 8'd255, "to_wait1");
    expect_at(50, 0, 1, 0, 0, 3'd1, 8'd255, "to_wait1_last");
    expect_at(51, 1, 1, 0, 0, 3'd2, 8'd255, "to_pulse2");
    expect_at(55, 0, 1, 0, 0, 3'd2, 8'd255, "to_wait2");
    expect_at(74, 0, 1, 0, 0, 3'd2, 8'd255, "to_wait2_last");
    expect_at(75, 1, 1, 0, 1, 3'd2, 8'd255, "to_fail");
    tick(85);

    // relock_req in FAIL.
    relock_req = 1'b1;
    expect_at(0, 1, 1, 0, 1, 3'd2, 8'd255, "fail_held");
    expect_at(1, 1, 1, 0, 0, 3'd0, 8'd255, "relock_in_fail");
    expect_at(4, 1, 1, 0, 0, 3'd0, 8'd255, "relock_fail_pulse_last");
    expect_at(5, 0, 1, 0, 0, 3'd0, 8'd255, "relock_fail_wait");
    tick(1);
    relock_req = 1'b0;
    tick(4);
    pll_locked = 1'b1;
    expect_at(5, 0, 1, 0, 0, 3'd0, 8'd255, "pre_async_stab");
    tick(6);

    // Asynchronous reset mid-STABILIZE, between clock edges.
    #1;
    rst = 1'b1;
    expect_at(0, 1, 1, 0, 0, 3'd0, 8'd0, "async_rst");
    tick(1);
    rst = 1'b0;
    expect_at(0,  1, 1, 0, 0, 3'd0, 8'd0, "rst_release");
    expect_at(3,  1, 1, 0, 0, 3'd0, 8'd0, "rst_pulse_last");
    expect_at(4,  0, 1, 0, 0, 3'd0, 8'd0, "rst_wait");
    expect_at(12, 0, 1, 0, 0, 3'd0, 8'd0, "rst_stab_last");
    expect_at(13, 0, 0, 1, 0, 3'd0, 8'd0, "rst_run");
    tick(15);

    while (q.size() > 0) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL %s: pending check for cycle %0d never sampled, expected %h", q[0].tag, q[0].cyc, q[0].val);
      q.delete(0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
